// File: rtl/load_store_unit_if.sv
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

// ============================================================================
//  Module      : load_store_unit_if
//  Description : Bundles the pipeline request/response signals and the
//                data-memory bus of the load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int WORD_SIZE = `WORD_SIZE
) ();
    // Pipeline side
    logic                 i_req;
    logic                 i_we;
    logic [2:0]           i_funct3;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_wdata;
    logic [WORD_SIZE-1:0] o_rdata;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
    // Data-memory side
    logic [WORD_SIZE-1:0] o_dm_Addr;
    logic [WORD_SIZE-1:0] o_dm_Wd;
    logic                 o_dm_Wen;
    logic                 o_dm_Ren;
    logic [WORD_SIZE-1:0] i_dm_Rd;

    // Load/store unit view
    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_dm_Rd,
        output o_rdata, o_busy, o_done, o_err,
               o_dm_Addr, o_dm_Wd, o_dm_Wen, o_dm_Ren
    );

    // Pipeline plus memory view
    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_dm_Rd,
        input  o_rdata, o_busy, o_done, o_err,
               o_dm_Addr, o_dm_Wd, o_dm_Wen, o_dm_Ren
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I load/store sequencer. Loads read one word and extract
//                the addressed lane; byte/halfword stores do a
//                read-modify-write; misaligned or illegal accesses complete
//                immediately with an error and no memory traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    load_store_unit_if.slave  bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [1:0]           r_state;
    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_merge;
    logic [WORD_SIZE-1:0] r_rdata;
    logic                 r_err;

    logic                 w_req_err;
    logic [7:0]           w_ld_byte;
    logic [15:0]          w_ld_half;
    logic [WORD_SIZE-1:0] w_load_val;
    logic [WORD_SIZE-1:0] w_store_word;

    // Flag illegal width codes, stores with an unsigned code, and misalignment
    always_comb begin
        w_req_err = 1'b0;
        case (bus.i_funct3)
            c_F3_B:  w_req_err = 1'b0;
            c_F3_H:  w_req_err = bus.i_addr[0];
            c_F3_W:  w_req_err = |bus.i_addr[1:0];
            c_F3_BU: w_req_err = bus.i_we;
            c_F3_HU: w_req_err = bus.i_we | bus.i_addr[0];
            default: w_req_err = 1'b1;
        endcase
    end

    // Pick the addressed little-endian lane of the read word and extend it
    always_comb begin
        w_ld_byte  = bus.i_dm_Rd[{r_addr[1:0], 3'b000} +: 8];
        w_ld_half  = bus.i_dm_Rd[{r_addr[1], 4'b0000} +: 16];
        w_load_val = bus.i_dm_Rd;
        case (r_funct3)
            c_F3_B:  w_load_val = {{(WORD_SIZE-8){w_ld_byte[7]}}, w_ld_byte};
            c_F3_H:  w_load_val = {{(WORD_SIZE-16){w_ld_half[15]}}, w_ld_half};
            c_F3_BU: w_load_val = {{(WORD_SIZE-8){1'b0}}, w_ld_byte};
            c_F3_HU: w_load_val = {{(WORD_SIZE-16){1'b0}}, w_ld_half};
            default: w_load_val = bus.i_dm_Rd;
        endcase
    end

    // Build the write word: replace only the target lane(s) of the merged word
    always_comb begin
        w_store_word = r_merge;
        case (r_funct3)
            c_F3_B:  w_store_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            c_F3_H:  w_store_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_store_word = r_wdata;
        endcase
    end

    // Access sequencer; reset aborts any access in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= c_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.i_req) begin
                        r_we     <= bus.i_we;
                        r_funct3 <= bus.i_funct3;
                        r_addr   <= bus.i_addr;
                        r_wdata  <= bus.i_wdata;
                        r_err    <= w_req_err;
                        r_rdata  <= '0;
                        if (w_req_err) begin
                            r_state <= c_DONE;
                        end else if (bus.i_we && (bus.i_funct3 == c_F3_W)) begin
                            r_state <= c_WR;
                        end else begin
                            r_state <= c_RD;
                        end
                    end
                end
                c_RD: begin
                    if (r_we) begin
                        r_merge <= bus.i_dm_Rd;
                        r_state <= c_WR;
                    end else begin
                        r_rdata <= w_load_val;
                        r_state <= c_DONE;
                    end
                end
                c_WR:    r_state <= c_DONE;
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.o_busy    = (r_state != c_IDLE);
    assign bus.o_done    = (r_state == c_DONE);
    assign bus.o_err     = r_err;
    assign bus.o_rdata   = r_rdata;
    assign bus.o_dm_Ren  = (r_state == c_RD);
    assign bus.o_dm_Wen  = (r_state == c_WR);
    assign bus.o_dm_Addr = {r_addr[WORD_SIZE-1:2], 2'b00};
    assign bus.o_dm_Wd   = (r_state == c_WR) ? w_store_word : '0;

endmodule

`default_nettype wire
